// File: rtl/csa_accumulate_sequencer.sv
// Frame accumulator: operands are folded into a redundant sum/carry pair with a 3:2
// compressor, and a single carry-propagate add resolves the frame total.
module csa_accumulate_sequencer #(
    parameter int N       = 8,
    parameter int MAX_OPS = 16,
    localparam int ACC_W  = N + $clog2(MAX_OPS),
    localparam int CNT_W  = $clog2(MAX_OPS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc,
    output logic             busy
);

    typedef enum logic [1:0] {ACC, RES, OUT} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

    state_t           state;
    logic [ACC_W-1:0] s;
    logic [ACC_W-1:0] c;
    logic [ACC_W-1:0] c2;
    logic [ACC_W-1:0] d;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             frame_full;

    // Carry vector carries weight 2, so the frame value is always s + (c << 1).
    assign c2         = {c[ACC_W-2:0], 1'b0};
    assign d          = ACC_W'(in_data);
    assign count_next = count + CNT_W'(1);
    assign frame_full = (count_next == MAX_CNT);

    assign in_ready = (state == ACC) && !flush;
    assign busy     = (count != '0) || (state != ACC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            s         <= '0;
            c         <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_trunc <= 1'b0;
        end else if (flush) begin
            state     <= ACC;
            s         <= '0;
            c         <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid) begin
                        s     <= s ^ c2 ^ d;
                        c     <= (s & c2) | (s & d) | (c2 & d);
                        count <= count_next;
                        if (in_last || frame_full) begin
                            state     <= RES;
                            out_trunc <= frame_full && !in_last;
                        end
                    end
                end
                RES: begin
                    out_sum   <= s + c2;
                    out_count <= count;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    // Result fields are left as-is after the handshake; only valid drops.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        s         <= '0;
                        c         <= '0;
                        count     <= '0;
                        state     <= ACC;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accumulate_sequencer.sv
// Self-checking bench for csa_accumulate_sequencer: directed frames plus randomized
// frames with stalls, compared against a frame-level reference model and scoreboard.
module tb_csa_accumulate_sequencer;

    localparam int N       = 8;
    localparam int MAX_OPS = 16;
    localparam int ACC_W   = 12;
    localparam int CNT_W   = 5;
    localparam int NUM_RANDOM_FRAMES = 120;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_trunc;
    logic             busy;

    int testsRun;
    int testsFailed;

    // Reference model: operands of the open frame, phase 0 collecting / 1 resolving / 2 presenting.
    int mQ[$];
    int mPhase;
    int mSum;
    int mCount;
    bit mTrunc;
    bit mValid;

    int  expQ[$];
    bit  scoreOn;
    int  handshakes;
    bit  lastAccepted;

    csa_accumulate_sequencer #(.N(N), .MAX_OPS(MAX_OPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_trunc (out_trunc),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelReset();
        mQ.delete();
        mPhase = 0;
        mSum   = 0;
        mCount = 0;
        mTrunc = 1'b0;
        mValid = 1'b0;
    endfunction

    function automatic void modelStep(input bit v, input int d, input bit last, input bit ordy, input bit fl);
        int total;
        if (fl) begin
            mQ.delete();
            mPhase = 0;
            mValid = 1'b0;
        end else begin
            case (mPhase)
                0: if (v) begin
                    mQ.push_back(d);
                    if (last || mQ.size() == MAX_OPS) begin
                        mTrunc = (mQ.size() == MAX_OPS) && !last;
                        mPhase = 1;
                    end
                end
                1: begin
                    total = 0;
                    foreach (mQ[i]) total += mQ[i];
                    mSum   = total % (1 << ACC_W);
                    mCount = mQ.size();
                    mValid = 1'b1;
                    mPhase = 2;
                end
                default: if (ordy) begin
                    mValid = 1'b0;
                    mQ.delete();
                    mPhase = 0;
                end
            endcase
        end
    endfunction

    // Drives one cycle of inputs, checks in_ready before the edge and all outputs after it.
    task automatic applyStimulus(input bit v, input logic [N-1:0] d, input bit last, input bit ordy, input bit fl);
        bit modelReady;
        in_valid  = v;
        in_data   = d;
        in_last   = last;
        out_ready = ordy;
        flush     = fl;
        #1;
        modelReady = (mPhase == 0) && !fl;
        checkOutput("in_ready", in_ready, modelReady);
        lastAccepted = modelReady && v;
        if (out_valid && out_ready && !flush) begin
            handshakes++;
            if (scoreOn)
                checkOutput("sb_sum", out_sum, (expQ.size() > 0) ? expQ.pop_front() : 32'hFFFF_FFFF);
        end
        @(posedge clk);
        #1;
        modelStep(v, int'(d), last, ordy, fl);
        checkOutput("out_valid", out_valid, mValid);
        checkOutput("busy", busy, (mQ.size() != 0) || (mPhase != 0));
        checkOutput("out_sum", out_sum, mSum);
        checkOutput("out_count", out_count, mCount);
        checkOutput("out_trunc", out_trunc, mTrunc);
    endtask

    initial begin
        int genOps[$];
        int framesLeft;
        int budget;
        int len;
        int total;
        bit noLast;
        bit v;
        logic [N-1:0] d;

        testsRun    = 0;
        testsFailed = 0;
        scoreOn     = 1'b0;
        handshakes  = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_sum", out_sum, 0);
        checkOutput("rst_out_count", out_count, 0);
        checkOutput("rst_out_trunc", out_trunc, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b0;

        // Frame 3,5,7: result appears one edge after the RES cycle.
        applyStimulus(1, 8'd3, 0, 1, 0);
        applyStimulus(1, 8'd5, 0, 1, 0);
        applyStimulus(1, 8'd7, 1, 1, 0);
        checkOutput("t1_valid_early", out_valid, 0);
        applyStimulus(0, 8'd0, 0, 1, 0);
        checkOutput("t1_valid", out_valid, 1);
        checkOutput("t1_sum", out_sum, 15);
        checkOutput("t1_count", out_count, 3);
        checkOutput("t1_trunc", out_trunc, 0);
        applyStimulus(0, 8'd0, 0, 1, 0);

        // Sixteen 255s without in_last: forced end of frame.
        repeat (MAX_OPS) applyStimulus(1, 8'd255, 0, 1, 0);
        checkOutput("t2_ready17", in_ready, 0);
        applyStimulus(1, 8'd255, 0, 0, 0);
        checkOutput("t2_sum", out_sum, 4080);
        checkOutput("t2_count", out_count, 16);
        checkOutput("t2_trunc", out_trunc, 1);
        applyStimulus(0, 8'd0, 0, 1, 0);

        // Single operand held against a stalled sink.
        applyStimulus(1, 8'd200, 1, 0, 0);
        applyStimulus(0, 8'd0, 0, 0, 0);
        repeat (5) begin
            applyStimulus(1, 8'd17, 0, 0, 0);
            checkOutput("t3_sum", out_sum, 200);
            checkOutput("t3_count", out_count, 1);
            checkOutput("t3_valid", out_valid, 1);
        end
        applyStimulus(0, 8'd0, 0, 1, 0);

        // Flush mid-frame drops the frame and the operand offered alongside it.
        applyStimulus(1, 8'd1, 0, 1, 0);
        applyStimulus(1, 8'd2, 0, 1, 0);
        applyStimulus(1, 8'd4, 0, 1, 1);
        checkOutput("t4_busy_after_flush", busy, 0);
        applyStimulus(1, 8'd9, 1, 1, 0);
        applyStimulus(0, 8'd0, 0, 1, 0);
        checkOutput("t4_sum", out_sum, 9);
        checkOutput("t4_count", out_count, 1);
        applyStimulus(0, 8'd0, 0, 1, 0);

        // Asynchronous reset between edges with two operands pending.
        applyStimulus(1, 8'd6, 0, 1, 0);
        applyStimulus(1, 8'd6, 0, 1, 0);
        checkOutput("t5_busy_before", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("t5_valid_rst", out_valid, 0);
        checkOutput("t5_busy_rst", busy, 0);
        modelReset();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1, 8'd6, 0, 1, 0);
        applyStimulus(1, 8'd6, 1, 1, 0);
        applyStimulus(0, 8'd0, 0, 1, 0);
        checkOutput("t5_sum", out_sum, 12);
        applyStimulus(0, 8'd0, 0, 1, 0);

        // Random frames with source and sink stalls, scored in delivery order.
        scoreOn    = 1'b1;
        handshakes = 0;
        framesLeft = NUM_RANDOM_FRAMES;
        noLast     = 1'b0;
        budget     = 20000;
        while ((framesLeft > 0 || genOps.size() > 0) && budget > 0) begin
            if (genOps.size() == 0) begin
                len    = $urandom_range(1, MAX_OPS);
                noLast = (len == MAX_OPS) && ($urandom_range(0, 1) == 1);
                total  = 0;
                for (int i = 0; i < len; i++) begin
                    genOps.push_back($urandom_range(0, 255));
                    total += genOps[i];
                end
                expQ.push_back(total);
                framesLeft--;
            end
            v = ($urandom_range(0, 3) != 0);
            d = v ? N'(genOps[0]) : N'($urandom);
            applyStimulus(v, d, v && (genOps.size() == 1) && !noLast, $urandom_range(0, 2) != 0, 0);
            if (lastAccepted) void'(genOps.pop_front());
            budget--;
        end
        repeat (6) applyStimulus(0, 8'd0, 0, 1, 0);
        checkOutput("rand_budget_left", genOps.size() + framesLeft, 0);
        checkOutput("rand_pending", expQ.size(), 0);
        checkOutput("rand_results", handshakes, NUM_RANDOM_FRAMES);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
